// File: rtl/nibble_pack32.sv
// -----------------------------------------------------------------------------
// nibble_pack32
//   Collects a stream of 4-bit nibbles and packs them into 4*NPW-bit words.
//   The first nibble of a word lands in the MSBs. A single output register
//   holds the finished word until the consumer takes it, so the nibble side
//   can keep filling the next word while that word waits. A FLUSH pulse emits
//   a partial word with zero padding in the LSBs.
//
// Parameters
//   NPW           nibbles per word (default 8 -> 32-bit words)
//
// Ports
//   CLK           clock, rising edge
//   RESET         asynchronous, active-high reset
//   NIBBLE_IN     incoming nibble
//   NIBBLE_VALID  NIBBLE_IN is valid this cycle
//   NIBBLE_READY  block can accept a nibble this cycle (registered, no path
//                 from WORD_READY)
//   FLUSH         single-cycle request to emit the partial word
//   WORD_OUT      assembled word
//   WORD_VALID    WORD_OUT holds a word the consumer has not yet taken
//   WORD_READY    consumer takes WORD_OUT this cycle
//   MAX_NIBBLE    largest nibble in WORD_OUT
//
// Configuration
//   NIBBLE_PACK_MAX_EN  when defined, tracks the largest accepted nibble of
//                       each word and registers it alongside WORD_OUT.
//                       When undefined, MAX_NIBBLE is tied to zero.
// -----------------------------------------------------------------------------
module nibble_pack32 #(
    parameter int NPW = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       NIBBLE_IN,
    input  logic             NIBBLE_VALID,
    output logic             NIBBLE_READY,
    input  logic             FLUSH,
    output logic [4*NPW-1:0] WORD_OUT,
    output logic             WORD_VALID,
    input  logic             WORD_READY,
    output logic [3:0]       MAX_NIBBLE
);

    localparam int W   = 4 * NPW;
    localparam int CW  = (NPW > 1) ? $clog2(NPW) : 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW-1:0] LAST  = CW'(NPW - 1);
    localparam logic [CW:0]   NPW_L = CW1'(NPW);

    // STALL: the last nibble slot is reached but the output register is full.
    typedef enum logic {FILL, STALL} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  word_q, word_d;
    logic          wv_q, wv_d;
    logic          pend_q, pend_d;

    logic          accept, take, complete, flush_req, word_load;
    logic [W-1:0]  acc_shift, acc_in;
    logic [CW:0]   n_nib;

    assign NIBBLE_READY = (state_q == FILL) && !RESET;
    assign WORD_OUT     = word_q;
    assign WORD_VALID   = wv_q;

    assign accept    = NIBBLE_VALID && NIBBLE_READY;
    assign take      = wv_q && WORD_READY;
    assign complete  = accept && (cnt_q == LAST);
    assign flush_req = FLUSH || pend_q;
    assign acc_shift = {acc_q[W-5:0], NIBBLE_IN};
    // A nibble accepted alongside a flush belongs to the flushed word.
    assign acc_in    = accept ? acc_shift : acc_q;
    assign n_nib     = {1'b0, cnt_q} + CW1'(accept);

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        wv_d      = wv_q;
        pend_d    = pend_q;
        word_load = 1'b0;

        if (take) begin
            wv_d = 1'b0;
        end

        if (complete) begin
            word_d    = acc_shift;
            wv_d      = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            word_load = 1'b1;
        end else if (accept) begin
            acc_d = acc_shift;
            cnt_d = cnt_q + CW'(1);
        end

        // A flush against a full output register waits in pend_q; it runs
        // on the first cycle the register is empty.
        if (flush_req) begin
            if (wv_q) begin
                pend_d = 1'b1;
            end else begin
                pend_d = 1'b0;
                if (!complete && (n_nib != '0)) begin
                    word_d    = acc_in << {NPW_L - n_nib, 2'b00};
                    wv_d      = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    word_load = 1'b1;
                end
            end
        end

        state_d = ((cnt_d == LAST) && wv_d) ? STALL : FILL;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= FILL;
            acc_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            wv_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wv_q    <= wv_d;
            pend_q  <= pend_d;
        end
    end

`ifdef NIBBLE_PACK_MAX_EN
    logic [3:0] run_max_q, run_max_d, run_in;
    logic [3:0] max_q, max_d;

    assign run_in     = (accept && (NIBBLE_IN > run_max_q)) ? NIBBLE_IN : run_max_q;
    assign MAX_NIBBLE = max_q;

    // Pad zeros never enter run_in, so they cannot raise the maximum.
    always_comb begin
        run_max_d = run_in;
        max_d     = max_q;
        if (word_load) begin
            max_d     = run_in;
            run_max_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            run_max_q <= '0;
            max_q     <= '0;
        end else begin
            run_max_q <= run_max_d;
            max_q     <= max_d;
        end
    end
`else
    assign MAX_NIBBLE = 4'h0;
`endif

`ifndef SYNTHESIS
    // A word can only complete into an empty register, so it never meets a take.
    a_no_complete_on_take : assert property (
        @(posedge CLK) disable iff (RESET) !(complete && take)
    );
`endif

endmodule

// File: tb/tb_nibble_pack32.sv
// -----------------------------------------------------------------------------
// tb_nibble_pack32
//   Directed bench for nibble_pack32 (NPW = 8). Inputs change 1 time unit
//   after the rising edge; outputs are read in the same window, well away
//   from the next edge. Expected MAX_NIBBLE values follow NIBBLE_PACK_MAX_EN.
// -----------------------------------------------------------------------------
module tb_nibble_pack32;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  nibble_in;
    logic        nibble_valid;
    logic        nibble_ready;
    logic        flush;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  max_nibble;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nibble_pack32 #(.NPW(8)) dut (
        .CLK          (clk),
        .RESET        (rst),
        .NIBBLE_IN    (nibble_in),
        .NIBBLE_VALID (nibble_valid),
        .NIBBLE_READY (nibble_ready),
        .FLUSH        (flush),
        .WORD_OUT     (word_out),
        .WORD_VALID   (word_valid),
        .WORD_READY   (word_ready),
        .MAX_NIBBLE   (max_nibble)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one nibble and hold it until accepted (bounded wait).
    task automatic send(input logic [3:0] n);
        int waits;
        nibble_in    = n;
        nibble_valid = 1'b1;
        waits        = 0;
        while (!nibble_ready && waits < 50) begin
            tick();
            waits++;
        end
        if (waits == 50) begin
            check("send_timeout_ready", {31'd0, nibble_ready}, 32'd1);
        end else begin
            tick();
        end
        nibble_valid = 1'b0;
    endtask

    function automatic logic [3:0] mx(input logic [3:0] v);
`ifdef NIBBLE_PACK_MAX_EN
        return v;
`else
        return 4'h0;
`endif
    endfunction

    initial begin
        rst          = 1'b1;
        nibble_in    = 4'h0;
        nibble_valid = 1'b0;
        flush        = 1'b0;
        word_ready   = 1'b1;

        // ---- Reset state ----
        #3;
        check("rst_word_out",     word_out,              32'h0);
        check("rst_word_valid",   {31'd0, word_valid},   32'd0);
        check("rst_nibble_ready", {31'd0, nibble_ready}, 32'd0);
        check("rst_max",          {28'd0, max_nibble},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle_nibble_ready", {31'd0, nibble_ready}, 32'd1);

        // ---- 1: 1..8 back-to-back, consumer ready ----
        for (int i = 1; i <= 7; i++) send(4'(i));
        check("t1_no_valid_before_8th", {31'd0, word_valid}, 32'd0);
        send(4'h8);
        check("t1_valid",     {31'd0, word_valid}, 32'd1);
        check("t1_word",      word_out,            32'h12345678);
        check("t1_max",       {28'd0, max_nibble}, {28'd0, mx(4'h8)});
        tick();
        check("t1_valid_one_cycle", {31'd0, word_valid}, 32'd0);
        check("t1_word_held",       word_out,            32'h12345678);

        // ---- 2: stalled consumer, 16 nibbles 0..F ----
        word_ready = 1'b0;
        for (int i = 0; i <= 14; i++) send(4'(i));
        check("t2_word1",        word_out,              32'h01234567);
        check("t2_valid1",       {31'd0, word_valid},   32'd1);
        check("t2_ready_stall",  {31'd0, nibble_ready}, 32'd0);
        nibble_in    = 4'hF;
        nibble_valid = 1'b1;
        tick();
        tick();
        check("t2_word1_stable", word_out,              32'h01234567);
        check("t2_still_stall",  {31'd0, nibble_ready}, 32'd0);
        word_ready = 1'b1;
        tick();
        check("t2_taken",        {31'd0, word_valid},   32'd0);
        check("t2_ready_back",   {31'd0, nibble_ready}, 32'd1);
        word_ready = 1'b0;
        tick();
        nibble_valid = 1'b0;
        check("t2_word2",        word_out,              32'h89ABCDEF);
        check("t2_valid2",       {31'd0, word_valid},   32'd1);
        check("t2_max2",         {28'd0, max_nibble},   {28'd0, mx(4'hF)});
        word_ready = 1'b1;
        tick();
        check("t2_word2_taken",  {31'd0, word_valid},   32'd0);

        // ---- 3: partial word flush ----
        send(4'hA);
        send(4'hB);
        send(4'hC);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_valid", {31'd0, word_valid}, 32'd1);
        check("t3_word",  word_out,            32'hABC00000);
        check("t3_max",   {28'd0, max_nibble}, {28'd0, mx(4'hC)});
        tick();
        check("t3_taken", {31'd0, word_valid}, 32'd0);

        // ---- 4: flush with empty accumulator, then flush while word held ----
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_empty_flush_a", {31'd0, word_valid}, 32'd0);
        tick();
        check("t4_empty_flush_b", {31'd0, word_valid}, 32'd0);
        word_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(4'(i));
        check("t4_held_word", word_out, 32'h12345678);
        send(4'h5);
        send(4'h6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_pending_valid", {31'd0, word_valid}, 32'd1);
        check("t4_pending_word",  word_out,            32'h12345678);
        tick();
        check("t4_pending_word2", word_out,            32'h12345678);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("t4_take",          {31'd0, word_valid}, 32'd0);
        tick();
        check("t4_flush_fired",   {31'd0, word_valid}, 32'd1);
        check("t4_flush_word",    word_out,            32'h56000000);
        check("t4_flush_max",     {28'd0, max_nibble}, {28'd0, mx(4'h6)});
        word_ready = 1'b1;
        tick();
        check("t4_flush_taken",   {31'd0, word_valid}, 32'd0);

        // ---- 5: reset mid-word ----
        for (int i = 1; i <= 5; i++) send(4'(i));
        rst = 1'b1;
        #2;
        check("t5_rst_word",  word_out,              32'h0);
        check("t5_rst_valid", {31'd0, word_valid},   32'd0);
        check("t5_rst_ready", {31'd0, nibble_ready}, 32'd0);
        check("t5_rst_max",   {28'd0, max_nibble},   32'd0);
        rst = 1'b0;
        tick();
        for (int i = 15; i >= 8; i--) send(4'(i));
        check("t5_word",  word_out,            32'hFEDCBA98);
        check("t5_valid", {31'd0, word_valid}, 32'd1);
        check("t5_max",   {28'd0, max_nibble}, {28'd0, mx(4'hF)});
        tick();

        // ---- 6: running maximum ----
        send(4'h3); send(4'h9); send(4'h1); send(4'h7);
        send(4'h0); send(4'h2); send(4'h5); send(4'h4);
        check("t6_word",  word_out,            32'h39170254);
        check("t6_valid", {31'd0, word_valid}, 32'd1);
        check("t6_max",   {28'd0, max_nibble}, {28'd0, mx(4'h9)});
        tick();
        check("t6_taken", {31'd0, word_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
